mmio_dev_port: RTL

// Device-side responder for the CPU memory-mapped I/O window (addr >= BASE_ADDR).

---
 rtl/mmio_dev_port.sv | 119 +++++++++++
 1 files changed

// File: rtl/mmio_dev_port.sv
// Device-side responder for the CPU MMIO window: status/data registers bridging one
// output stream and one input stream, plus a free-running cycle counter.
module mmio_dev_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dm_addr,
  input  logic        dm_w_dev_en,
  input  logic        dm_r_dev_en,
  input  logic [31:0] dm_w_data,
  output logic [31:0] dm_r_data_dev,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam logic [31:0] OFF_OUT_STAT = 32'h00;
  localparam logic [31:0] OFF_OUT_DATA = 32'h04;
  localparam logic [31:0] OFF_IN_STAT  = 32'h08;
  localparam logic [31:0] OFF_IN_DATA  = 32'h0c;
  localparam logic [31:0] OFF_CYCLE    = 32'h10;

  logic [31:0]      off;
  logic [31:0]      word_off;
  logic             ovf;
  logic             in_full;
  logic [31:0]      in_buf;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cnt_ext;

  logic out_xfer;
  logic in_xfer;
  logic wr_out_stat;
  logic wr_out_data;
  logic wr_cycle;
  logic rd_in_data;

  // Addresses below the base wrap to huge offsets and fall into the "other" decode.
  assign off      = dm_addr - BASE_ADDR;
  assign word_off = {off[31:2], 2'b00};

  assign out_xfer    = out_valid & out_ready;
  assign in_ready    = ~in_full;
  assign in_xfer     = in_valid & in_ready;
  assign wr_out_stat = dm_w_dev_en && (word_off == OFF_OUT_STAT);
  assign wr_out_data = dm_w_dev_en && (word_off == OFF_OUT_DATA);
  assign wr_cycle    = dm_w_dev_en && (word_off == OFF_CYCLE);
  assign rd_in_data  = dm_r_dev_en && (word_off == OFF_IN_DATA);

  always_comb begin
    cnt_ext = '0;
    cnt_ext[CNT_W-1:0] = cnt;
  end

  always_comb begin
    dm_r_data_dev = 32'h0;
    if (dm_r_dev_en) begin
      case (word_off)
        OFF_OUT_STAT: dm_r_data_dev = {30'b0, ovf, ~out_valid};
        OFF_OUT_DATA: dm_r_data_dev = out_data;
        OFF_IN_STAT:  dm_r_data_dev = {31'b0, in_full};
        OFF_IN_DATA:  dm_r_data_dev = in_buf;
        OFF_CYCLE:    dm_r_data_dev = cnt_ext;
        default:      dm_r_data_dev = 32'h0;
      endcase
    end
  end

  // A store landing in the same cycle as a transfer replaces the departing word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      ovf       <= 1'b0;
    end else begin
      if (wr_out_data) begin
        if (!out_valid || out_xfer) begin
          out_data  <= dm_w_data;
          out_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (wr_out_stat) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_full <= 1'b0;
      in_buf  <= 32'h0;
    end else if (in_xfer) begin
      in_buf  <= in_data;
      in_full <= 1'b1;
    end else if (rd_in_data) begin
      in_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (wr_cycle) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
